// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared CPU-wide constants and types.
//   Register-file geometry is defined here so the register file and the
//   debug dump sequencer (regs_dump) always agree on data width, address
//   width and register count.
// ----------------------------------------------------------------------------
package cpu_pkg;

    // Register data width (immediate width equals the architectural word).
    localparam int unsigned IMM_WIDTH      = 32;

    // Register index width and derived register count.
    localparam int unsigned REG_ADDR_WIDTH = 3;
    localparam int unsigned NUM_REGS       = 2 ** REG_ADDR_WIDTH;

    // Debug register-dump sequencer states.
    typedef enum logic [1:0] {
        DUMP_IDLE  = 2'd0,
        DUMP_FETCH = 2'd1,
        DUMP_SEND  = 2'd2
    } dump_state_t;

endpackage : cpu_pkg

// File: rtl/regs_dump.sv
// ----------------------------------------------------------------------------
// regs_dump
//   Debug read-out sequencer on the register file's read side. A start pulse
//   walks every register address on one read port, captures the
//   combinational read result and streams {address, data} out over a
//   valid/ready handshake. The register file is never written; each word is
//   whatever the register held in the cycle it was fetched.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   start      in   one-cycle dump request, honoured only when idle
//   abort      in   abandon the dump in progress (wins over start/handshake)
//   raddr      out  register-file read address
//   rdata      in   combinational read data for raddr
//   out_valid  out  out_data/out_addr/out_last hold a word
//   out_ready  in   consumer accepts the word
//   out_data   out  captured register value
//   out_addr   out  register index of out_data
//   out_last   out  current word is the highest register
//   busy       out  sequencer is not idle
//   done       out  one-cycle pulse after the last word is accepted
// ----------------------------------------------------------------------------
module regs_dump
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = IMM_WIDTH,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter bit          SKIP_R0    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    // R0 is hard-wired to zero, so it is normally not worth dumping.
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = SKIP_R0 ? ADDR_WIDTH'(1) : '0;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

    dump_state_t           state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic                  out_last_q;
    logic                  busy_q;
    logic                  done_q;

    // Sequencer: state, pointer and registered output bank.
    // raddr_q mirrors ptr_q whenever a dump is active and is 0 when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= DUMP_IDLE;
            ptr_q       <= '0;
            raddr_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                DUMP_IDLE: begin
                    raddr_q <= '0;
                    // abort in the same cycle cancels the request
                    if (start && !abort) begin
                        state_q <= DUMP_FETCH;
                        ptr_q   <= FIRST_ADDR;
                        raddr_q <= FIRST_ADDR;
                        busy_q  <= 1'b1;
                    end
                end

                DUMP_FETCH: begin
                    if (abort) begin
                        state_q     <= DUMP_IDLE;
                        raddr_q     <= '0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else begin
                        out_data_q  <= rdata;
                        out_addr_q  <= ptr_q;
                        out_last_q  <= (ptr_q == LAST_ADDR);
                        out_valid_q <= 1'b1;
                        state_q     <= DUMP_SEND;
                    end
                end

                DUMP_SEND: begin
                    // abort beats a simultaneous handshake: word not transferred
                    if (abort) begin
                        state_q     <= DUMP_IDLE;
                        raddr_q     <= '0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            state_q <= DUMP_IDLE;
                            raddr_q <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            // out_last_q guards the increment, so ptr never wraps
                            ptr_q   <= ptr_q + ADDR_WIDTH'(1);
                            raddr_q <= ptr_q + ADDR_WIDTH'(1);
                            state_q <= DUMP_FETCH;
                        end
                    end
                end

                default: begin
                    state_q     <= DUMP_IDLE;
                    raddr_q     <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign raddr     = raddr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : regs_dump

// File: tb/tb_regs_dump.sv
// ----------------------------------------------------------------------------
// tb_regs_dump
//   Bench for regs_dump. Two instances share clock, reset and control inputs:
//   u_a skips R0, u_b dumps from R0. A behavioural register file answers both
//   read ports; the expected word stream is derived from the register
//   contents and the handshake timing rules.
// ----------------------------------------------------------------------------
module tb_regs_dump;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          out_ready;

    logic [AW-1:0] a_raddr, b_raddr;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          a_valid, b_valid;
    logic [DW-1:0] a_data,  b_data;
    logic [AW-1:0] a_addr,  b_addr;
    logic          a_last,  b_last;
    logic          a_busy,  b_busy;
    logic          a_done,  b_done;

    logic [DW-1:0] regs [8];

    int checks = 0;
    int errors = 0;

    // Which instance the dump task is observing (1 = u_b).
    logic          sel = 1'b0;
    logic          o_valid, o_last, o_busy, o_done;
    logic [DW-1:0] o_data;
    logic [AW-1:0] o_addr, o_raddr;

    always #5 clk = ~clk;

    assign a_rdata = regs[a_raddr];
    assign b_rdata = regs[b_raddr];

    assign o_valid = sel ? b_valid : a_valid;
    assign o_last  = sel ? b_last  : a_last;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;
    assign o_data  = sel ? b_data  : a_data;
    assign o_addr  = sel ? b_addr  : a_addr;
    assign o_raddr = sel ? b_raddr : a_raddr;

    regs_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SKIP_R0(1'b1)) u_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .raddr(a_raddr), .rdata(a_rdata), .out_valid(a_valid), .out_ready(out_ready),
        .out_data(a_data), .out_addr(a_addr), .out_last(a_last),
        .busy(a_busy), .done(a_done)
    );

    regs_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SKIP_R0(1'b0)) u_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .raddr(b_raddr), .rdata(b_rdata), .out_valid(b_valid), .out_ready(out_ready),
        .out_data(b_data), .out_addr(b_addr), .out_last(b_last),
        .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until both instances are idle.
    task automatic settle();
        int n = 0;
        out_ready = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        while ((a_busy || b_busy) && n < 100) begin
            tick();
            n++;
        end
        chk("settle_idle", 32'(a_busy || b_busy), 32'(0));
        out_ready = 1'b0;
        tick();
    endtask

    // One dump, checked cycle by cycle against the expected word stream.
    // ready_pct: chance out_ready is high while a word is presented.
    // stall_addr: hold out_ready low 5 cycles on this word (-1 = none).
    // restart_addr: pulse start while this word is presented (-1 = none).
    // abort_addr: abort with out_ready=1 on this word (-1 = none).
    task automatic dump(input bit use_b, input int ready_pct, input int stall_addr,
                        input int restart_addr, input int abort_addr);
        int exp_addr, next_valid, done_cyc, busy_cnt, stalls, stall_left, cyc, tail, nwords;
        bit aborted, ended, finished, exp_valid, rdy;
        sel        = use_b;
        nwords     = use_b ? 8 : 7;
        exp_addr   = use_b ? 0 : 1;
        next_valid = 2;
        done_cyc   = -1;
        busy_cnt   = 0;
        stalls     = 0;
        stall_left = 5;
        tail       = 0;
        aborted    = 1'b0;
        ended      = 1'b0;
        finished   = 1'b0;
        start      = 1'b1;
        abort      = 1'b0;
        out_ready  = 1'($urandom_range(0, 1));
        tick();
        cyc = 1;
        while (!finished && cyc < 400) begin
            start = 1'b0;
            abort = 1'b0;
            if (cyc == done_cyc) begin
                chk("done_pulse", 32'(o_done), 32'(1));
                chk("done_valid", 32'(o_valid), 32'(0));
                chk("done_busy", 32'(o_busy), 32'(0));
                chk("done_raddr", 32'(o_raddr), 32'(0));
                chk("busy_cycles", busy_cnt, 2 * nwords + stalls);
                ended = 1'b1;
            end else if (aborted || ended) begin
                chk("idle_done", 32'(o_done), 32'(0));
                chk("idle_valid", 32'(o_valid), 32'(0));
                chk("idle_busy", 32'(o_busy), 32'(0));
                chk("idle_raddr", 32'(o_raddr), 32'(0));
                tail++;
                if (tail == 3) finished = 1'b1;
            end else begin
                exp_valid = (cyc >= next_valid);
                if (o_busy) busy_cnt++;
                chk("run_done", 32'(o_done), 32'(0));
                chk("run_busy", 32'(o_busy), 32'(1));
                chk("run_valid", 32'(o_valid), 32'(exp_valid));
                chk("run_raddr", 32'(o_raddr), exp_addr);
                if (exp_valid) begin
                    chk("word_addr", 32'(o_addr), exp_addr);
                    chk("word_data", o_data, regs[exp_addr]);
                    chk("word_last", 32'(o_last), 32'(exp_addr == 7));
                    if (exp_addr == restart_addr) start = 1'b1;
                    if (exp_addr == abort_addr) begin
                        abort   = 1'b1;
                        rdy     = 1'b1;
                        aborted = 1'b1;
                    end else if (exp_addr == stall_addr && stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                    end else begin
                        rdy = ($urandom_range(0, 99) < ready_pct);
                    end
                    if (!rdy) begin
                        stalls++;
                    end else if (!aborted) begin
                        if (exp_addr == 7) done_cyc = cyc + 1;
                        else begin
                            exp_addr++;
                            next_valid = cyc + 2;
                        end
                    end
                end else begin
                    rdy = 1'($urandom_range(0, 1));
                end
                out_ready = rdy;
            end
            tick();
            cyc++;
        end
        chk("dump_terminated", 32'(finished), 32'(1));
        settle();
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) regs[i] = '0;
        #1;
        chk("rst_valid", 32'(a_valid), 32'(0));
        chk("rst_busy", 32'(a_busy), 32'(0));
        chk("rst_raddr", 32'(a_raddr), 32'(0));
        chk("rst_data", a_data, 32'(0));
        chk("rst_done", 32'(a_done | b_done), 32'(0));
        #20;
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Preload R1..R7 with 0x11..0x77
        for (int i = 1; i < 8; i++) regs[i] = 32'(i * 32'h11);

        dump(1'b0, 100, -1, -1, -1);   // full dump, ready held high
        dump(1'b0, 100,  3, -1, -1);   // backpressure on addr 3
        dump(1'b1, 100, -1, -1, -1);   // R0 included
        dump(1'b0, 100, -1,  2, -1);   // start while busy is ignored
        dump(1'b0, 100, -1, -1,  4);   // abort on addr 4
        dump(1'b0, 100, -1, -1, -1);   // restart after abort begins at R1

        // Random register contents and random backpressure
        for (int r = 0; r < 4; r++) begin
            for (int i = 1; i < 8; i++) regs[i] = $urandom;
            dump(r[0], 50, -1, -1, -1);
        end

        // start together with abort while idle: stays idle
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 32'(a_busy | b_busy), 32'(0));

        // abort during FETCH
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fetch_busy", 32'(a_busy), 32'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("fetch_abort_busy", 32'(a_busy), 32'(0));
        chk("fetch_abort_valid", 32'(a_valid), 32'(0));
        tick();
        chk("fetch_abort_done", 32'(a_done), 32'(0));
        settle();

        // Asynchronous reset while a word is presented
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_reset_valid", 32'(a_valid), 32'(1));
        #1 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(a_valid), 32'(0));
        chk("async_rst_data", a_data, 32'(0));
        chk("async_rst_addr", 32'(a_addr), 32'(0));
        chk("async_rst_last", 32'(a_last), 32'(0));
        chk("async_rst_busy", 32'(a_busy | b_busy), 32'(0));
        chk("async_rst_raddr", 32'(a_raddr), 32'(0));
        chk("async_rst_done", 32'(a_done), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_rst_idle", 32'(a_busy | a_valid), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_regs_dump

// File: doc/regs_dump.md
Name: regs_dump

Overview:
- Debug read-out sequencer on the register file's read side.
- On a start pulse it walks every register address on one read port and captures each combinational read result.
- Each captured word streams out with its address over a valid/ready handshake, to a debug UART or testbench monitor.
- It never writes the register file; the CPU may keep running, so each word is whatever the register held in its fetch cycle.

Parameters:
- DATA_WIDTH, cpu_pkg::IMM_WIDTH: register data width.
- ADDR_WIDTH, cpu_pkg::REG_ADDR_WIDTH: register address width; NUM_REGS = 2**ADDR_WIDTH.
- SKIP_R0, 1: when 1, the dump starts at R1 (R0 reads constant 0); when 0, it starts at R0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
- abort  input  1  abandon the dump in progress.
- raddr  output  ADDR_WIDTH  read address driven to a register-file read port.
- rdata  input  DATA_WIDTH  combinational read data returned for raddr.
- out_valid  output  1  out_data/out_addr hold a valid word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_WIDTH  captured register value.
- out_addr  output  ADDR_WIDTH  register index of out_data.
- out_last  output  1  current word is register NUM_REGS-1.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async, any state): state=IDLE, ptr=0, raddr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0.
- States: IDLE, FETCH, SEND.
- IDLE:
  - raddr=0.
  - start=1 -> ptr = SKIP_R0 ? 1 : 0, go to FETCH.
  - start=1 together with abort=1 -> stay in IDLE; abort wins.
- FETCH (one cycle):
  - raddr=ptr.
  - At the clock edge: out_data<=rdata, out_addr<=ptr, out_last<=(ptr==NUM_REGS-1), out_valid<=1, go to SEND.
- SEND:
  - raddr holds ptr.
  - out_valid=1; out_data, out_addr and out_last stay stable until the handshake.
  - Handshake is out_valid & out_ready at a rising edge.
  - On handshake with out_last=0: ptr<=ptr+1, out_valid<=0, go to FETCH.
  - On handshake with out_last=1: out_valid<=0, done<=1 for exactly one cycle, go to IDLE.
- Throughput: 2 cycles per word with out_ready held high.
  - Dump latency is start -> first out_valid = 2 edges (start sampled, then FETCH).
  - Total dump is 2*N cycles plus the start cycle, where N = NUM_REGS - SKIP_R0.
- abort:
  - Sampled in FETCH or SEND; takes priority over the handshake.
  - Next state IDLE, out_valid<=0, no done pulse.
  - A word presented in the same cycle as abort is not considered transferred.
- start while busy: ignored, with no restart and no queueing.
- ptr width is ADDR_WIDTH. Increment happens only when out_last=0, so ptr never wraps.
- Coherency: no snapshot is taken. A register-file write in the same cycle as FETCH of that address is seen only if the register file has already updated; the register file's writes are synchronous, so the pre-write value is captured.
- out_valid never falls without a handshake, except on abort or reset.
- out_ready while out_valid=0 has no effect.

Decomposition:
- cpu_pkg additions:
  - typedef enum logic [1:0] {DUMP_IDLE, DUMP_FETCH, DUMP_SEND} dump_state_t.
  - NUM_REGS localparam derived from REG_ADDR_WIDTH, shared with the register file.
- No sub-module: one state register, one pointer and one output register bank.
- Top level instantiates the register file with an extra read port (or a muxed raddr2) fed from raddr.

Test Plan:
- Reset and idle: assert reset mid-SEND -> all outputs 0 immediately, without waiting for a clock edge; state=IDLE.
- Full dump, SKIP_R0=1, out_ready=1, R1..R7 preloaded 0x11..0x77:
  - 7 words (addr 1..7, data 0x11..0x77), out_valid every other cycle.
  - out_last only on addr 7; done pulses 1 cycle after that word; busy for 14 cycles after start.
- Backpressure: hold out_ready=0 for 5 cycles on addr 3 -> out_valid, out_data=0x33 and out_addr=3 stay stable; raddr stays 3; on release, addr 4 follows 2 cycles later.
- SKIP_R0=0 -> 8 words; first is addr 0, data 0; last is addr 7.
- start pulsed while busy at addr 2 -> sequence continues unchanged, a single done pulse.
- Abort:
  - abort during SEND at addr 4 with out_ready=1 -> no transfer, IDLE next cycle, done never asserts.
  - New start afterwards -> restarts at addr 1.
